adc_sys_top: RTL and testbench
==============================

// Module: adc_sys_top
// PURPOSE
//  Top of the dual-channel 14-bit ADC capture system (AD9xxx-class, ports A/B). Single sys_clk domain
//  (50 MHz) drives a divided ADC sample clock to both converters and holds them out of shutdown.
//  Captures both data buses plus overflow bits and produces per-window min/max/peak-to-peak for each channel.
//  Measurement results feed downstream debug/ILA and control logic.
// PARAMETERS
//  ADC_W    14    ADC data width
//  CLK_DIV  2     sys_clk cycles per ADC clock period; even, >=2
//  WIN_LEN  1024  samples per measurement window; >=2
//  OFFSET_BIN 1   1: ADC bus is offset binary (MSB inverted to get two's complement); 0: already signed
// PORTS
//  sys_clk        in   1        system clock, 50 MHz; all logic on rising edge
//  sys_rst        in   1        synchronous, active-high reset
//  ad_porta_data  in   ADC_W    channel A sample bus
//  ad_portb_data  in   ADC_W    channel B sample bus
//  ad_ofa/ad_ofb  in   1        channel A/B overrange flag, aligned with the data bus
//  ad_shdna/b     out  1        converter shutdown, 1 = shut down
//  ad_porta_clk/ad_portb_clk out 1  ADC sample clocks, identical
//  a_data/b_data  out  ADC_W    last captured sample, signed
//  a_valid/b_valid out 1        1-cycle pulse, new sample on a_data/b_data
//  a_min/a_max, b_min/b_max out ADC_W  signed extremes of last completed window
//  a_p2p/b_p2p    out  ADC_W+1  unsigned max-min of last completed window
//  a_ovf/b_ovf    out  1        any overrange sample in last completed window
//  meas_valid     out  1        1-cycle pulse, window results updated (both channels)
// BEHAVIOUR
//  - Reset (sys_rst=1 at a clock edge): every register cleared to 0; ad_shdna/b=1; ad clocks=0;
//    phase counter=0; trackers re-armed (min=+max, max=-min); sample count=0. Reset mid-window discards it.
//  - First edge after reset release: ad_shdna/b=0, held 0 until the next reset.
//  - Clock gen: phase cnt 0..CLK_DIV-1, wraps. ad_portX_clk is registered, 1 when cnt<CLK_DIV/2, else 0.
//    Both ports are always equal. Default gives 25 MHz, 50% duty.
//  - Capture strobe: on the edge where cnt==CLK_DIV/2 (ADC clk falling, mid data-eye), register
//    ad_portX_data and ad_ofX.
//  - Conversion: signed = OFFSET_BIN ? {~d[MSB], d[MSB-1:0]} : d.
//    Example: 0x2000 -> 0, 0x3FFF -> +8191, 0x0000 -> -8192.
//  - X_data updates on the strobe edge; X_valid=1 for exactly that cycle. Latency: 1 clock from strobe edge.
//  - Tracking is per channel, on each valid: min/max compare against the signed sample; ovf_acc |= of.
//    The sample counter increments.
//  - Window end: when the counter reaches WIN_LEN (that sample included), on the same edge:
//    latch min/max/ovf_acc to X_min/X_max/X_ovf; X_p2p = max - min, computed ADC_W+1 wide with no overflow.
//    Also pulse meas_valid, re-arm trackers, clear the counter. No sample is lost at the boundary.
//  - X_min/X_max/X_p2p/X_ovf hold between windows; 0 until the first window completes.
//  - Inputs are treated as source-synchronous to the generated clock: a single capture register, no synchronizer.
// STRUCTURE
//  - Package adc_pkg: ADC_W constant, typedef adc_smp_t (logic signed [ADC_W-1:0]),
//    function ob_to_signed(), tracker re-arm constants SMP_MAX/SMP_MIN.
//  - Sub-module adc_chan_meas (capture register, conversion, min/max/ovf tracker, window latch).
//    Instantiated twice (A, B), driven by a common strobe and window-end from the top.
//  - Top: reset/shutdown control, phase counter, clock outputs, shared sample/window counter.
// TESTING
//  1. Reset then release: ad_shdna/b=1 during reset, 0 on the first edge after; all result outputs 0.
//  2. CLK_DIV=2: ad_porta_clk period 40 ns, 50% duty, equal to ad_portb_clk; X_valid pulses every 2 clocks.
//  3. A held at 0x3FFF -> a_data=+8191 one clock after strobe; 0x0000 -> -8192; 0x2000 -> 0.
//  4. WIN_LEN=16, A alternating 0x0000/0x3FFF -> at meas_valid a_min=-8192, a_max=8191, a_p2p=16383.
//  5. Constant 0x2000 window -> p2p=0; one sample with ad_ofb=1 -> b_ovf=1 that window, 0 the next clean window.
//  6. Assert sys_rst after 8 of 16 samples -> no meas_valid; the next full window reports only post-reset samples.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and helpers for the dual-channel ADC capture path.
// Combinational helpers only: no latency, no backpressure.
package adc_pkg;
    localparam int ADC_W = 14;

    typedef logic signed [ADC_W-1:0] adc_smp_t;

    localparam adc_smp_t SMP_MAX = {1'b0, {(ADC_W-1){1'b1}}};
    localparam adc_smp_t SMP_MIN = {1'b1, {(ADC_W-1){1'b0}}};

    typedef struct packed {
        adc_smp_t         min;
        adc_smp_t         max;
        logic [ADC_W:0]   p2p;
        logic             ovf;
    } meas_t;

    function automatic adc_smp_t ob_to_signed(input logic [ADC_W-1:0] d, input logic offset_bin);
        adc_smp_t s;
        s = offset_bin ? adc_smp_t'({~d[ADC_W-1], d[ADC_W-2:0]}) : adc_smp_t'(d);
        return s;
    endfunction
endpackage

// File: rtl/adc_chan_meas.sv
// One ADC channel: capture register, sign conversion, min/max/ovf window tracker.
// Sample out 1 clk after strobe, window results 1 clk after win_end; no backpressure (free-running).
module adc_chan_meas
    import adc_pkg::*;
#(
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic             win_end,
    input  logic [ADC_W-1:0] raw,
    input  logic             of_in,
    output adc_smp_t         data,
    output logic             valid,
    output meas_t            meas
);
    logic     of_q;
    adc_smp_t trk_min;
    adc_smp_t trk_max;
    logic     trk_ovf;
    adc_smp_t nxt_min;
    adc_smp_t nxt_max;
    logic     nxt_ovf;

    // Tracker state including the sample currently on data, so the closing sample counts.
    always_comb begin
        nxt_min = (data < trk_min) ? data : trk_min;
        nxt_max = (data > trk_max) ? data : trk_max;
        nxt_ovf = trk_ovf | of_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            of_q    <= 1'b0;
            valid   <= 1'b0;
            trk_min <= SMP_MAX;
            trk_max <= SMP_MIN;
            trk_ovf <= 1'b0;
            meas    <= '0;
        end else begin
            valid <= strobe;
            if (strobe) begin
                data <= ob_to_signed(raw, OFFSET_BIN);
                of_q <= of_in;
            end
            if (win_end) begin
                meas.min <= nxt_min;
                meas.max <= nxt_max;
                meas.p2p <= {nxt_max[ADC_W-1], nxt_max} - {nxt_min[ADC_W-1], nxt_min};
                meas.ovf <= nxt_ovf;
                trk_min  <= SMP_MAX;
                trk_max  <= SMP_MIN;
                trk_ovf  <= 1'b0;
            end else if (valid) begin
                trk_min <= nxt_min;
                trk_max <= nxt_max;
                trk_ovf <= nxt_ovf;
            end
        end
    end
endmodule

// File: rtl/adc_sys_top.sv
// Dual ADC capture top: sample-clock generation, shutdown control, shared window counter.
// Samples 1 clk after capture strobe, window results 1 clk after last sample; no backpressure.
module adc_sys_top
    import adc_pkg::*;
#(
    parameter int ADC_W      = adc_pkg::ADC_W,
    parameter int CLK_DIV    = 2,
    parameter int WIN_LEN    = 1024,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [ADC_W-1:0]        ad_porta_data,
    input  logic [ADC_W-1:0]        ad_portb_data,
    input  logic                    ad_ofa,
    input  logic                    ad_ofb,
    output logic                    ad_shdna,
    output logic                    ad_shdnb,
    output logic                    ad_porta_clk,
    output logic                    ad_portb_clk,
    output logic signed [ADC_W-1:0] a_data,
    output logic signed [ADC_W-1:0] b_data,
    output logic                    a_valid,
    output logic                    b_valid,
    output logic signed [ADC_W-1:0] a_min,
    output logic signed [ADC_W-1:0] a_max,
    output logic signed [ADC_W-1:0] b_min,
    output logic signed [ADC_W-1:0] b_max,
    output logic [ADC_W:0]          a_p2p,
    output logic [ADC_W:0]          b_p2p,
    output logic                    a_ovf,
    output logic                    b_ovf,
    output logic                    meas_valid
);
    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = $clog2(CLK_DIV);
    localparam int NW   = $clog2(WIN_LEN);

    logic [CW-1:0] ph;
    logic [CW-1:0] ph_nxt;
    logic [NW-1:0] smp_cnt;
    logic          strobe;
    logic          win_end;
    logic          clk_q;
    logic          shdn;
    meas_t         meas_a;
    meas_t         meas_b;

    // Capture at the ADC clock falling edge, mid data-eye.
    assign strobe  = (ph == CW'(HALF));
    assign ph_nxt  = (ph == CW'(CLK_DIV - 1)) ? '0 : ph + CW'(1);
    assign win_end = a_valid && (smp_cnt == NW'(WIN_LEN - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ph         <= '0;
            clk_q      <= 1'b0;
            shdn       <= 1'b1;
            smp_cnt    <= '0;
            meas_valid <= 1'b0;
        end else begin
            ph         <= ph_nxt;
            clk_q      <= (ph_nxt < CW'(HALF));
            shdn       <= 1'b0;
            meas_valid <= win_end;
            if (win_end)
                smp_cnt <= '0;
            else if (a_valid)
                smp_cnt <= smp_cnt + NW'(1);
        end
    end

    assign ad_porta_clk = clk_q;
    assign ad_portb_clk = clk_q;
    assign ad_shdna     = shdn;
    assign ad_shdnb     = shdn;

    adc_chan_meas #(.OFFSET_BIN(OFFSET_BIN)) u_chan_a (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .strobe  (strobe),
        .win_end (win_end),
        .raw     (ad_porta_data),
        .of_in   (ad_ofa),
        .data    (a_data),
        .valid   (a_valid),
        .meas    (meas_a)
    );

    adc_chan_meas #(.OFFSET_BIN(OFFSET_BIN)) u_chan_b (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .strobe  (strobe),
        .win_end (win_end),
        .raw     (ad_portb_data),
        .of_in   (ad_ofb),
        .data    (b_data),
        .valid   (b_valid),
        .meas    (meas_b)
    );

    assign a_min = meas_a.min;
    assign a_max = meas_a.max;
    assign a_p2p = meas_a.p2p;
    assign a_ovf = meas_a.ovf;
    assign b_min = meas_b.min;
    assign b_max = meas_b.max;
    assign b_p2p = meas_b.p2p;
    assign b_ovf = meas_b.ovf;
endmodule

// File: tb/tb_adc_sys_top.sv
// Randomized bench for adc_sys_top with a queue-based window model (CLK_DIV=2, WIN_LEN=16).
module tb_adc_sys_top;
    localparam int W  = 14;
    localparam int CD = 2;
    localparam int WL = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [W-1:0]  ad_porta_data = '0;
    logic [W-1:0]  ad_portb_data = '0;
    logic          ad_ofa = 1'b0;
    logic          ad_ofb = 1'b0;
    logic          ad_shdna, ad_shdnb, ad_porta_clk, ad_portb_clk;
    logic [W-1:0]  a_data, b_data, a_min, a_max, b_min, b_max;
    logic          a_valid, b_valid, a_ovf, b_ovf, meas_valid;
    logic [W:0]    a_p2p, b_p2p;

    adc_sys_top #(.CLK_DIV(CD), .WIN_LEN(WL), .OFFSET_BIN(1'b1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .ad_porta_data(ad_porta_data), .ad_portb_data(ad_portb_data),
        .ad_ofa(ad_ofa), .ad_ofb(ad_ofb),
        .ad_shdna(ad_shdna), .ad_shdnb(ad_shdnb),
        .ad_porta_clk(ad_porta_clk), .ad_portb_clk(ad_portb_clk),
        .a_data(a_data), .b_data(b_data), .a_valid(a_valid), .b_valid(b_valid),
        .a_min(a_min), .a_max(a_max), .b_min(b_min), .b_max(b_max),
        .a_p2p(a_p2p), .b_p2p(b_p2p), .a_ovf(a_ovf), .b_ovf(b_ovf),
        .meas_valid(meas_valid)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    int vectors = 0;
    int errs    = 0;

    // Reference model: samples of the open window, as plain integers.
    int qa[$];
    int qb[$];
    bit oa_acc, ob_acc, pend;
    int e_amin, e_amax, e_bmin, e_bmax, e_ap2p, e_bp2p;
    bit e_aovf, e_bovf;
    int last_vcyc = -1;

    // Offset binary: code minus mid-scale.
    function automatic int conv(input logic [W-1:0] r);
        return int'(r) - (1 << (W - 1));
    endfunction

    task automatic drive_sample(input logic [W-1:0] a, input logic [W-1:0] b, input logic oa, input logic ob);
        bit got;
        int n;
        int mn, mx;
        got = 0;
        n = 0;
        ad_porta_data = a; ad_portb_data = b; ad_ofa = oa; ad_ofb = ob;
        while (!got && n < 4 * CD) begin
            @(negedge sys_clk);
            n++;
            vectors++;
            if (meas_valid !== pend) begin
                errs++; $display("FAIL meas_valid: got %b want %b (cycle %0d)", meas_valid, pend, cyc);
            end
            if (pend) begin
                pend = 1'b0;
                vectors++;
                if (int'($signed(a_min)) !== e_amin || int'($signed(a_max)) !== e_amax || int'(a_p2p) !== e_ap2p || a_ovf !== e_aovf) begin
                    errs++; $display("FAIL a_window: got min %0d max %0d p2p %0d ovf %b want %0d %0d %0d %b",
                        $signed(a_min), $signed(a_max), a_p2p, a_ovf, e_amin, e_amax, e_ap2p, e_aovf);
                end
                vectors++;
                if (int'($signed(b_min)) !== e_bmin || int'($signed(b_max)) !== e_bmax || int'(b_p2p) !== e_bp2p || b_ovf !== e_bovf) begin
                    errs++; $display("FAIL b_window: got min %0d max %0d p2p %0d ovf %b want %0d %0d %0d %b",
                        $signed(b_min), $signed(b_max), b_p2p, b_ovf, e_bmin, e_bmax, e_bp2p, e_bovf);
                end
            end
            if (a_valid === 1'b1) begin
                got = 1;
                vectors++;
                if (int'($signed(a_data)) !== conv(a) || int'($signed(b_data)) !== conv(b) || b_valid !== 1'b1) begin
                    errs++; $display("FAIL sample: got a %0d b %0d bvld %b want a %0d b %0d bvld 1",
                        $signed(a_data), $signed(b_data), b_valid, conv(a), conv(b));
                end
                if (last_vcyc >= 0) begin
                    vectors++;
                    if (cyc - last_vcyc !== CD) begin
                        errs++; $display("FAIL valid_period: got %0d cycles want %0d", cyc - last_vcyc, CD);
                    end
                end
                last_vcyc = cyc;
                qa.push_back(conv(a));
                qb.push_back(conv(b));
                oa_acc |= oa;
                ob_acc |= ob;
                if (qa.size() == WL) begin
                    mn = qa[0]; mx = qa[0];
                    foreach (qa[i]) begin
                        if (qa[i] < mn) mn = qa[i];
                        if (qa[i] > mx) mx = qa[i];
                    end
                    e_amin = mn; e_amax = mx; e_ap2p = mx - mn; e_aovf = oa_acc;
                    mn = qb[0]; mx = qb[0];
                    foreach (qb[i]) begin
                        if (qb[i] < mn) mn = qb[i];
                        if (qb[i] > mx) mx = qb[i];
                    end
                    e_bmin = mn; e_bmax = mx; e_bp2p = mx - mn; e_bovf = ob_acc;
                    qa.delete(); qb.delete();
                    oa_acc = 1'b0; ob_acc = 1'b0;
                    pend = 1'b1;
                end
            end
        end
        if (!got) begin
            errs++; $display("FAIL valid_timeout: got no a_valid in %0d cycles want one", 4 * CD);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        vectors++;
        if (ad_shdna !== 1'b1 || ad_shdnb !== 1'b1 || ad_porta_clk !== 1'b0 || ad_portb_clk !== 1'b0) begin
            errs++; $display("FAIL reset_ctl: got shdn %b%b clk %b%b want 11 00", ad_shdna, ad_shdnb, ad_porta_clk, ad_portb_clk);
        end
        vectors++;
        if ({a_data, b_data, a_min, a_max, b_min, b_max, a_p2p, b_p2p, a_ovf, b_ovf, a_valid, b_valid, meas_valid} !== '0) begin
            errs++; $display("FAIL reset_outputs: got amin %0d amax %0d ap2p %0d bp2p %0d meas %b want all 0",
                $signed(a_min), $signed(a_max), a_p2p, b_p2p, meas_valid);
        end
        qa.delete(); qb.delete();
        oa_acc = 1'b0; ob_acc = 1'b0; pend = 1'b0; last_vcyc = -1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        vectors++;
        if (ad_shdna !== 1'b0 || ad_shdnb !== 1'b0) begin
            errs++; $display("FAIL shdn_release: got %b%b want 00", ad_shdna, ad_shdnb);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_clock();
        logic prev;
        int highs;
        highs = 0;
        prev = ad_porta_clk;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            vectors++;
            if (ad_porta_clk !== ad_portb_clk || ad_porta_clk === prev) begin
                errs++; $display("FAIL adc_clk: got a %b b %b prev %b want a==b toggling every 20 ns", ad_porta_clk, ad_portb_clk, prev);
            end
            if (ad_porta_clk === 1'b1) highs++;
            prev = ad_porta_clk;
        end
        vectors++;
        if (highs !== 4) begin
            errs++; $display("FAIL adc_clk_duty: got %0d high of 8 want 4", highs);
        end
    endtask

    task automatic test_conversion();
        logic [W-1:0] codes [3];
        codes[0] = 14'h3FFF; codes[1] = 14'h0000; codes[2] = 14'h2000;
        do_reset();
        for (int i = 0; i < 3; i++)
            drive_sample(codes[i], W'($urandom_range(0, 16383)), 1'b0, 1'b0);
        for (int i = 3; i < WL; i++)
            drive_sample(W'($urandom_range(0, 16383)), W'($urandom_range(0, 16383)), 1'b0, 1'b0);
    endtask

    task automatic test_window_alt();
        for (int i = 0; i < WL; i++)
            drive_sample((i % 2 == 0) ? 14'h0000 : 14'h3FFF, W'($urandom_range(0, 16383)), 1'b0, 1'b0);
    endtask

    task automatic test_const_ovf();
        for (int i = 0; i < WL; i++)
            drive_sample(14'h2000, 14'h2000, 1'b0, (i == 5));
        for (int i = 0; i < WL; i++)
            drive_sample(14'h2000, W'($urandom_range(8000, 8400)), 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3 * WL; i++)
            drive_sample(W'($urandom_range(0, 16383)), W'($urandom_range(0, 16383)),
                         ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++)
            drive_sample((i % 2 == 0) ? 14'h0000 : 14'h3FFF, (i % 2 == 0) ? 14'h3FFF : 14'h0000, 1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < WL; i++)
            drive_sample(W'($urandom_range(8100, 8300)), W'($urandom_range(8100, 8300)), 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2 * WL; i++)
            drive_sample(W'($urandom_range(0, 16383)), W'($urandom_range(0, 16383)), 1'b0, 1'b0);
        drive_sample(14'h2000, 14'h2000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_clock();
        test_conversion();
        test_window_alt();
        test_const_ovf();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
